sdram_init_monitor: RTL and testbench

//  Command-bus responder/checker for the SDRAM power-up sequence. Samples the {cs,ras,cas,we}/bank/addr
//  bus that the SDRAM initialiser drives, in parallel with the SDRAM device. Decodes each command and

---
 rtl/sdram_init_monitor_pkg.sv | 47 ++++
 rtl/sdram_cmd_decode.sv | 50 +++++
 rtl/sdram_init_monitor.sv | 145 ++++++++++++++
 tb/tb_sdram_init_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_init_monitor_pkg.sv
// Shared definitions for the SDRAM init monitor: command codes, FSM states, violation codes.
// Optional mode-word check is enabled by defining SDRAM_MON_MRCHK_EN.
package sdram_init_monitor_pkg;

    localparam int GAP_W = 16;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [2:0] {
        S_POWER = 3'd0,
        S_TRP   = 3'd1,
        S_TRFC  = 3'd2,
        S_TMRD  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } mon_state_t;

    typedef enum logic [3:0] {
        E_NONE     = 4'd0,
        E_EARLY    = 4'd1,
        E_ORDER    = 4'd2,
        E_PRE_BANK = 4'd3,
        E_TRP      = 4'd4,
        E_TRFC     = 4'd5,
        E_AR_FEW   = 4'd6,
        E_ILLEGAL  = 4'd7,
        E_TMRD     = 4'd8,
        E_MODE     = 4'd9
    } mon_err_t;

    typedef struct packed {
        logic nop;
        logic pre;
        logic ar;
        logic lmr;
        logic illegal;
    } cmd_dec_t;

    function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Registers the SDRAM command bus once and decodes the registered copy one-hot.
// valid stays low until the first real bus sample after reset release.
module sdram_cmd_decode
    import sdram_init_monitor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cmd,
    input  logic [1:0]  bank,
    input  logic [12:0] addr,
    output logic        valid,
    output cmd_dec_t    dec,
    output logic [1:0]  bank_q,
    output logic [12:0] addr_q
);

    logic [3:0] cmd_reg;
    logic       valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg   <= CMD_NOP;
            bank_q    <= '0;
            addr_q    <= '0;
            valid_reg <= 1'b0;
        end else begin
            cmd_reg   <= cmd;
            bank_q    <= bank;
            addr_q    <= addr;
            valid_reg <= 1'b1;
        end
    end

    assign valid = valid_reg;

    always_comb begin
        dec = '0;
        if (cmd_reg[3] || cmd_reg == CMD_NOP) begin
            dec.nop = 1'b1;
        end else begin
            case (cmd_reg)
                CMD_PRE: dec.pre     = 1'b1;
                CMD_AR:  dec.ar      = 1'b1;
                CMD_LMR: dec.lmr     = 1'b1;
                default: dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_monitor.sv
// Checks order and timing of the SDRAM power-up command sequence and captures the mode word.
// Define SDRAM_MON_MRCHK_EN to also compare the mode word and bank against MR_EXPECT.
module sdram_init_monitor
    import sdram_init_monitor_pkg::*;
#(
    parameter int          T_POWER   = 20000,
    parameter int          TRP_CYC   = 2,
    parameter int          TRFC_CYC  = 7,
    parameter int          TMRD_CYC  = 3,
    parameter int          AR_NUM    = 8,
    parameter logic [12:0] MR_EXPECT = 13'h037
)(
    input  logic        mon_clk,
    input  logic        mon_rst_n,
    input  logic [3:0]  mon_cmd,
    input  logic [1:0]  mon_bank,
    input  logic [12:0] mon_addr,
    output logic        mon_init_ok,
    output logic        mon_err,
    output logic [3:0]  mon_err_code,
    output logic [12:0] mon_mode_reg,
    output logic [3:0]  mon_ar_cnt,
    output logic [2:0]  mon_state
);

    // Gap thresholds expressed as NOP counts between two commands.
    localparam logic [GAP_W-1:0] POWER_MIN = GAP_W'(T_POWER);
    localparam logic [GAP_W-1:0] TRP_MIN   = GAP_W'(TRP_CYC - 1);
    localparam logic [GAP_W-1:0] TRFC_MIN  = GAP_W'(TRFC_CYC - 1);
    localparam logic [GAP_W:0]   TMRD_MIN  = (GAP_W + 1)'(TMRD_CYC - 1);
    localparam logic [3:0]       AR_MIN    = 4'(AR_NUM);

    logic              valid;
    cmd_dec_t          dec;
    logic [1:0]        bank_q;
    logic [12:0]       addr_q;

    mon_state_t        state_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [3:0]        ar_cnt_reg;
    logic [12:0]       mode_reg;
    logic              err_reg;
    mon_err_t          err_code_reg;
    logic              init_ok_reg;
    mon_err_t          viol;

    sdram_cmd_decode u_decode (
        .clk    (mon_clk),
        .rst_n  (mon_rst_n),
        .cmd    (mon_cmd),
        .bank   (mon_bank),
        .addr   (mon_addr),
        .valid  (valid),
        .dec    (dec),
        .bank_q (bank_q),
        .addr_q (addr_q)
    );

`ifndef SDRAM_MON_MRCHK_EN
    // Mode word is captured but not compared in this build.
    logic [14:0] mrchk_unused;
    assign mrchk_unused = {bank_q, MR_EXPECT};
`endif

    always_comb begin
        viol = E_NONE;
        if (valid && !dec.nop) begin
            case (state_reg)
                S_POWER: begin
                    if (dec.illegal)               viol = E_ILLEGAL;
                    else if (gap_cnt_reg < POWER_MIN) viol = E_EARLY;
                    else if (!dec.pre)             viol = E_ORDER;
                    else if (!addr_q[10])          viol = E_PRE_BANK;
                end
                S_TRP: begin
                    if (dec.illegal)               viol = E_ILLEGAL;
                    else if (gap_cnt_reg < TRP_MIN) viol = E_TRP;
                    else if (!dec.ar)              viol = E_ORDER;
                end
                S_TRFC: begin
                    if (dec.illegal)               viol = E_ILLEGAL;
                    else if (gap_cnt_reg < TRFC_MIN) viol = E_TRFC;
                    else if (dec.pre)              viol = E_ORDER;
                    else if (dec.lmr && ar_cnt_reg < AR_MIN) viol = E_AR_FEW;
`ifdef SDRAM_MON_MRCHK_EN
                    else if (dec.lmr && (addr_q != MR_EXPECT || bank_q != 2'b00)) viol = E_MODE;
`endif
                end
                S_TMRD: begin
                    if (dec.illegal)               viol = E_ILLEGAL;
                    else                           viol = E_TMRD;
                end
                default: viol = E_NONE;
            endcase
        end
    end

    always_ff @(posedge mon_clk or negedge mon_rst_n) begin
        if (!mon_rst_n) begin
            state_reg    <= S_POWER;
            gap_cnt_reg  <= '0;
            ar_cnt_reg   <= '0;
            mode_reg     <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= E_NONE;
            init_ok_reg  <= 1'b0;
        end else if (valid) begin
            gap_cnt_reg <= dec.nop ? gap_sat_inc(gap_cnt_reg) : '0;
            if (viol != E_NONE) begin
                err_reg      <= 1'b1;
                err_code_reg <= viol;
                state_reg    <= S_ERR;
            end else begin
                case (state_reg)
                    S_POWER: if (dec.pre) state_reg <= S_TRP;
                    S_TRP, S_TRFC: begin
                        if (dec.ar) begin
                            state_reg <= S_TRFC;
                            if (ar_cnt_reg != 4'hF) ar_cnt_reg <= ar_cnt_reg + 4'd1;
                        end else if (dec.lmr) begin
                            mode_reg  <= addr_q;
                            state_reg <= S_TMRD;
                        end
                    end
                    S_TMRD: begin
                        // Enough NOPs once this one brings the count to TMRD_CYC-1.
                        if (dec.nop && ({1'b0, gap_cnt_reg} + 1'b1) >= TMRD_MIN) begin
                            state_reg   <= S_DONE;
                            init_ok_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign mon_init_ok  = init_ok_reg;
    assign mon_err      = err_reg;
    assign mon_err_code = err_code_reg;
    assign mon_mode_reg = mode_reg;
    assign mon_ar_cnt   = ar_cnt_reg;
    assign mon_state    = state_reg;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Scoreboard bench for sdram_init_monitor: expectations are queued as commands are driven
// and compared one cycle after the command has passed the monitor's input register.
module tb_sdram_init_monitor;
    import sdram_init_monitor_pkg::*;

    localparam int T_POWER = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cmd = 4'b0111;
    logic [1:0]  bank = '0;
    logic [12:0] addr = '0;
    logic        init_ok, err;
    logic [3:0]  err_code, ar_cnt;
    logic [12:0] mode_reg;
    logic [2:0]  state;

    always #5 clk = ~clk;

    sdram_init_monitor #(.T_POWER(T_POWER)) dut (
        .mon_clk      (clk),
        .mon_rst_n    (rst_n),
        .mon_cmd      (cmd),
        .mon_bank     (bank),
        .mon_addr     (addr),
        .mon_init_ok  (init_ok),
        .mon_err      (err),
        .mon_err_code (err_code),
        .mon_mode_reg (mode_reg),
        .mon_ar_cnt   (ar_cnt),
        .mon_state    (state)
    );

    typedef struct {
        string       tag;
        int          due;
        logic        ok;
        logic        er;
        logic [3:0]  code;
        int          ar;    // -1 = not checked
        int          mode;  // -1 = not checked
        int          st;    // -1 = not checked
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            $display("txn %-14s cyc=%0d ok=%0b err=%0b code=%0d ar=%0d mode=%03h st=%0d",
                     e.tag, cyc, init_ok, err, err_code, ar_cnt, mode_reg, state);
            chk({e.tag, ".due"}, 32'(cyc), 32'(e.due));
            chk({e.tag, ".init_ok"}, 32'(init_ok), 32'(e.ok));
            chk({e.tag, ".err"}, 32'(err), 32'(e.er));
            chk({e.tag, ".code"}, 32'(err_code), 32'(e.code));
            if (e.ar >= 0)   chk({e.tag, ".ar_cnt"}, 32'(ar_cnt), 32'(e.ar));
            if (e.mode >= 0) chk({e.tag, ".mode"}, 32'(mode_reg), 32'(e.mode));
            if (e.st >= 0)   chk({e.tag, ".state"}, 32'(state), 32'(e.st));
        end
    endtask

    task automatic push_exp(input string tag, input int due, input logic ok, input logic er,
                            input logic [3:0] code, input int ar, input int mode, input int st);
        exp_t e;
        e.tag = tag; e.due = due; e.ok = ok; e.er = er; e.code = code;
        e.ar = ar; e.mode = mode; e.st = st;
        sb.push_back(e);
    endtask

    // Expectation for the effect of the command driven in the last step.
    task automatic expect_next(input string tag, input logic ok, input logic er,
                               input logic [3:0] code, input int ar, input int mode, input int st);
        push_exp(tag, cyc + 1, ok, er, code, ar, mode, st);
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        cmd = c; bank = b; addr = a;
        @(negedge clk);
        cyc++;
        drain();
    endtask

    // Mix of explicit NOP and deselect (cs_n=1) codes with junk on the other lines.
    task automatic nops(input int n);
        logic [3:0] c;
        for (int i = 0; i < n; i++) begin
            c = ($urandom_range(0, 1) == 1) ? 4'b0111 : {1'b1, 3'($urandom)};
            step(c, 2'($urandom), 13'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd = 4'b0111;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        push_exp("reset", cyc, 1'b0, 1'b0, 4'd0, 0, 0, int'(S_POWER));
        drain();
        rst_n = 1'b1;
    endtask

    // Power-up sequence up to and including LOAD MODE; bad_gap replaces the 6 NOPs after AR bad_idx.
    task automatic run_init(input int pnops, input int n_ar, input int bad_idx, input int bad_gap,
                            input logic [12:0] mr);
        nops(pnops);
        step(CMD_PRE, 2'b11, 13'h0400);
        nops(1);
        for (int i = 0; i < n_ar; i++) begin
            step(CMD_AR, 2'b00, 13'h0000);
            nops((i == bad_idx) ? bad_gap : 6);
        end
        step(CMD_LMR, 2'b00, mr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);

        // 1: legal sequence, init_ok appears exactly after the 2nd NOP following LOAD MODE
        do_reset();
        run_init(T_POWER, 8, -1, 6, 13'h037);
        expect_next("t1_lmr", 1'b0, 1'b0, 4'd0, 8, 13'h037, int'(S_TMRD));
        nops(1);
        expect_next("t1_nop1", 1'b0, 1'b0, 4'd0, 8, 13'h037, int'(S_TMRD));
        nops(1);
        expect_next("t1_done", 1'b1, 1'b0, 4'd0, 8, 13'h037, int'(S_DONE));
        nops(3);
        expect_next("t1_hold", 1'b1, 1'b0, 4'd0, 8, 13'h037, int'(S_DONE));
        nops(1);

        // 2: PRE after 10 NOPs, then the rest of a legal sequence
        do_reset();
        run_init(10, 8, -1, 6, 13'h037);
        nops(2);
        expect_next("t2_early", 1'b0, 1'b1, 4'd1, -1, -1, int'(S_ERR));
        nops(1);

        // power-up boundary: one NOP short
        do_reset();
        nops(T_POWER - 1);
        step(CMD_PRE, 2'b00, 13'h0400);
        expect_next("t2_early_b", 1'b0, 1'b1, 4'd1, 0, 0, int'(S_ERR));
        nops(1);

        // 3: AR only 3 NOPs after the previous AR; later violations keep code 5
        do_reset();
        run_init(T_POWER, 8, 1, 3, 13'h037);
        step(CMD_PRE, 2'b00, 13'h0000);
        nops(2);
        expect_next("t3_trfc", 1'b0, 1'b1, 4'd5, -1, -1, int'(S_ERR));
        nops(1);

        // 4: LOAD MODE after only 7 ARs
        do_reset();
        run_init(T_POWER, 7, -1, 6, 13'h037);
        expect_next("t4_ar_few", 1'b0, 1'b1, 4'd6, 7, 0, int'(S_ERR));
        nops(2);

        // 4: PRE with A10=0
        do_reset();
        nops(T_POWER);
        step(CMD_PRE, 2'b01, 13'h0000);
        expect_next("t4_pre_bank", 1'b0, 1'b1, 4'd3, 0, 0, int'(S_ERR));
        nops(1);

        // wrong first command
        do_reset();
        nops(T_POWER);
        step(CMD_AR, 2'b00, 13'h0000);
        expect_next("order", 1'b0, 1'b1, 4'd2, -1, 0, int'(S_ERR));
        nops(1);

        // illegal code (ACTIVE) before init completes
        do_reset();
        nops(T_POWER);
        step(4'b0011, 2'b00, 13'h0000);
        expect_next("illegal", 1'b0, 1'b1, 4'd7, 0, 0, int'(S_ERR));
        nops(1);

        // AR directly after PRE
        do_reset();
        nops(T_POWER);
        step(CMD_PRE, 2'b00, 13'h0400);
        step(CMD_AR, 2'b00, 13'h0000);
        expect_next("trp", 1'b0, 1'b1, 4'd4, 0, 0, int'(S_ERR));
        nops(1);

        // AR one NOP after LOAD MODE
        do_reset();
        run_init(T_POWER, 8, -1, 6, 13'h037);
        nops(1);
        step(CMD_AR, 2'b00, 13'h0000);
        expect_next("tmrd", 1'b0, 1'b1, 4'd8, 8, 13'h037, int'(S_ERR));
        nops(1);

        // 5: non-default mode word
        do_reset();
        run_init(T_POWER, 8, -1, 6, 13'h033);
        nops(2);
`ifdef SDRAM_MON_MRCHK_EN
        expect_next("t5_mode", 1'b0, 1'b1, 4'd9, -1, -1, int'(S_ERR));
`else
        expect_next("t5_mode", 1'b1, 1'b0, 4'd0, 8, 13'h033, int'(S_DONE));
`endif
        nops(1);

        // 6: reset after the 4th AR, then a full legal replay and post-init traffic
        do_reset();
        nops(T_POWER);
        step(CMD_PRE, 2'b00, 13'h0400);
        nops(1);
        for (int i = 0; i < 4; i++) begin
            step(CMD_AR, 2'b00, 13'h0000);
            if (i < 3) nops(6);
        end
        expect_next("t6_ar4", 1'b0, 1'b0, 4'd0, 4, 0, int'(S_TRFC));
        nops(1);
        do_reset();
        run_init(T_POWER, 8, -1, 6, 13'h037);
        nops(2);
        expect_next("t6_done", 1'b1, 1'b0, 4'd0, 8, 13'h037, int'(S_DONE));
        step(4'b0011, 2'b10, 13'h0123);
        step(4'b0101, 2'b10, 13'h0010);
        expect_next("t6_traffic", 1'b1, 1'b0, 4'd0, 8, 13'h037, int'(S_DONE));
        nops(2);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
